// File: rtl/vga_text_pkg.sv
// Shared types and constants for the text-mode renderer: state encoding,
// cell attribute field positions and the 16-entry CGA palette.
package vga_text_pkg;

  typedef enum logic [1:0] {
    BLANK      = 2'd0,
    PRIME_CELL = 2'd1,
    PRIME_FONT = 2'd2,
    ACTIVE     = 2'd3
  } render_state_t;

  localparam int CHAR_W    = 8;
  localparam int FG_LSB    = 8;
  localparam int BG_LSB    = 12;
  localparam int BLINK_BIT = 15;

  // Entry i sits at PALETTE[i]; listed from index 15 down to 0.
  localparam logic [15:0][11:0] PALETTE = {
    12'hFFF, 12'hFF5, 12'hF5F, 12'hF55, 12'h5FF, 12'h5F5, 12'h55F, 12'h555,
    12'hAAA, 12'hA50, 12'hA0A, 12'hA00, 12'h0AA, 12'h0A0, 12'h00A, 12'h000
  };

endpackage

// File: rtl/vga_text_render_if.sv
// Text buffer / font ROM read port. The renderer is the master (drives the
// addresses); the memories are the slave (return data one cycle later).
interface vga_text_render_if #(
  parameter int AW = 14,
  parameter int FW = 12,
  parameter int LW = 8
);
  logic [AW-1:0] cell_addr;
  logic [15:0]   cell_data;
  logic [FW-1:0] font_addr;
  logic [LW-1:0] font_line;

  modport master (output cell_addr, output font_addr, input cell_data, input font_line);
  modport slave  (input cell_addr, input font_addr, output cell_data, output font_line);
endinterface

// File: rtl/vga_blink_timer.sv
// Counts frame ticks and toggles blink_phase every BLINK_FRAMES ticks.
module vga_blink_timer #(
  parameter int BLINK_FRAMES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  output logic blink_phase
);
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/vga_text_render.sv
// Text-mode pixel renderer: prefetches cell + glyph line one cell ahead of the
// beam and emits registered 4:4:4 colour one cycle after the beam position.
//
// state      | meaning
// BLANK      | beam outside active area; row base address issued
// PRIME_CELL | first cell of the coming line captured, glyph line requested
// PRIME_FONT | glyph captured into cur/next; waiting for disp
// ACTIVE     | drawing; next cell fetched during the current cell
module vga_text_render
  import vga_text_pkg::*;
#(
  parameter int  H_DISP       = 1280,
  parameter int  V_DISP       = 1024,
  parameter int  GLYPH_W      = 8,
  parameter int  GLYPH_H      = 16,
  parameter int  BLINK_FRAMES = 32,
  localparam int COLS = H_DISP / GLYPH_W,
  localparam int ROWS = V_DISP / GLYPH_H,
  localparam int XW   = $clog2(H_DISP),
  localparam int YW   = $clog2(V_DISP),
  localparam int AW   = $clog2(COLS * ROWS),
  localparam int GW   = $clog2(GLYPH_H),
  localparam int CW   = $clog2(COLS),
  localparam int RW   = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          disp,
  input  logic [XW-1:0] x_pos,
  input  logic [YW-1:0] y_pos,
  input  logic          frame_tick,
  input  logic          cursor_en,
  input  logic [CW-1:0] cursor_col,
  input  logic [RW-1:0] cursor_row,
  vga_text_render_if.master mem,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b
);
  localparam int PW = $clog2(GLYPH_W);

  render_state_t state, state_nxt;
  logic blank_seen;
  logic row_ld, cell_ld, prime_ld, line_ld, cur_ld;

  logic [PW-1:0]      p;
  logic [GW-1:0]      g;
  logic [RW-1:0]      row;
  logic [CW-1:0]      fetch_col;
  logic [AW-1:0]      row_base;
  logic               cur_hit;
  logic               blink_phase;

  logic [AW-1:0]      cell_addr_q;
  logic [CHAR_W+GW-1:0] font_addr_q;
  logic [15:0]        next_cell, cur_cell;
  logic [GLYPH_W-1:0] next_line, cur_line;
  logic               next_cur, cur_cur;
  logic               pix_on;
  logic [11:0]        pix_rgb, rgb_q;

  assign p         = x_pos[PW-1:0];
  assign g         = y_pos[GW-1:0];
  assign row       = RW'(y_pos >> GW);
  assign row_base  = AW'(row) * AW'(COLS);
  assign fetch_col = (state == ACTIVE) ? CW'(x_pos >> PW) + CW'(1) : '0;
  assign cur_hit   = cursor_en && (cursor_col == fetch_col) && (cursor_row == row);

  vga_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .blink_phase (blink_phase)
  );

  // blank_seen guarantees the row address has been on the bus a full cycle
  // before PRIME_CELL samples the synchronous text buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BLANK;
      blank_seen <= 1'b0;
    end else begin
      state      <= state_nxt;
      blank_seen <= (state == BLANK) && !disp;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BLANK:      if (!disp && blank_seen) state_nxt = PRIME_CELL;
      PRIME_CELL: state_nxt = disp ? BLANK : PRIME_FONT;
      PRIME_FONT: if (disp) state_nxt = ACTIVE;
      ACTIVE:     if (!disp) state_nxt = BLANK;
      default:    state_nxt = BLANK;
    endcase
  end

  // Glyph data is captured at p=3, the first phase where the ROM output for
  // the address issued at p=1 is valid.
  always_comb begin
    row_ld   = 1'b0;
    cell_ld  = 1'b0;
    prime_ld = 1'b0;
    line_ld  = 1'b0;
    cur_ld   = 1'b0;
    case (state)
      BLANK:      row_ld   = 1'b1;
      PRIME_CELL: cell_ld  = 1'b1;
      PRIME_FONT: prime_ld = 1'b1;
      ACTIVE: begin
        if (disp) begin
          cell_ld = (p == PW'(1));
          line_ld = (p == PW'(3));
          cur_ld  = (p == PW'(GLYPH_W - 1));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cell_addr_q <= '0;
      font_addr_q <= '0;
      next_cell   <= '0;
      cur_cell    <= '0;
      next_line   <= '0;
      cur_line    <= '0;
      next_cur    <= 1'b0;
      cur_cur     <= 1'b0;
    end else begin
      if (row_ld)        cell_addr_q <= row_base;
      else if (prime_ld) cell_addr_q <= row_base + AW'(1);
      else if (cur_ld)   cell_addr_q <= cell_addr_q + AW'(1);

      if (cell_ld) begin
        next_cell   <= mem.cell_data;
        next_cur    <= cur_hit;
        font_addr_q <= {mem.cell_data[CHAR_W-1:0], g};
      end

      if (line_ld || prime_ld) next_line <= mem.font_line;

      if (prime_ld) begin
        cur_line <= mem.font_line;
        cur_cell <= next_cell;
        cur_cur  <= next_cur;
      end else if (cur_ld) begin
        cur_line <= line_ld ? mem.font_line : next_line;
        cur_cell <= next_cell;
        cur_cur  <= next_cur;
      end
    end
  end

  always_comb begin
    pix_on = cur_line[p];
    if (cur_cell[BLINK_BIT] && blink_phase) pix_on = 1'b0;
    if (cur_cur && (g >= GW'(GLYPH_H - 2)) && !blink_phase) pix_on = 1'b1;
    pix_rgb = pix_on ? PALETTE[cur_cell[FG_LSB +: 4]]
                     : PALETTE[{1'b0, cur_cell[BG_LSB +: 3]}];
  end

  always_ff @(posedge clk) begin
    if (reset)     rgb_q <= '0;
    else if (disp) rgb_q <= pix_rgb;
    else           rgb_q <= '0;
  end

  assign mem.cell_addr = cell_addr_q;
  assign mem.font_addr = font_addr_q;
  assign vga_r = rgb_q[11:8];
  assign vga_g = rgb_q[7:4];
  assign vga_b = rgb_q[3:0];
endmodule

// File: tb/tb_vga_text_render.sv
// Directed bench for vga_text_render (1280x1024, 8x16 glyphs, blink every 2
// frames). Blank cycles preceding a line carry that line's y_pos.
module tb_vga_text_render;
  localparam int BF = 2;
  localparam int HB = 16;

  logic        clk = 1'b0;
  logic        reset, disp, frame_tick, cursor_en;
  logic [10:0] x_pos;
  logic [9:0]  y_pos;
  logic [7:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic [11:0] rgb;

  logic [15:0] text_mem [16384];
  logic [7:0]  font_rom [4096];

  int checks = 0;
  int failures = 0;
  int tick_count = 0;
  int pix_bad, fetch_bad, saw_prime, prime_addr;
  logic [11:0] line_buf [1280];

  vga_text_render_if #(.AW(14), .FW(12), .LW(8)) mem_if ();

  vga_text_render #(
    .H_DISP(1280), .V_DISP(1024), .GLYPH_W(8), .GLYPH_H(16), .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .disp       (disp),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .frame_tick (frame_tick),
    .cursor_en  (cursor_en),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .mem        (mem_if.master),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b)
  );

  always #5 clk = ~clk;
  assign rgb = {vga_r, vga_g, vga_b};

  always @(posedge clk) begin
    mem_if.cell_data <= text_mem[mem_if.cell_addr];
    mem_if.font_line <= font_rom[mem_if.font_addr];
  end

  task automatic chk_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ref_pal(input int i);
    case (i)
      0: return 12'h000;  1: return 12'h00A;  2: return 12'h0A0;  3: return 12'h0AA;
      4: return 12'hA00;  5: return 12'hA0A;  6: return 12'hA50;  7: return 12'hAAA;
      8: return 12'h555;  9: return 12'h55F; 10: return 12'h5F5; 11: return 12'h5FF;
      12: return 12'hF55; 13: return 12'hF5F; 14: return 12'hFF5; default: return 12'hFFF;
    endcase
  endfunction

  function automatic logic [11:0] model_rgb(input int x, input int y);
    logic [15:0] c;
    logic [7:0]  fl;
    logic        on;
    bit          ph;
    ph = ((tick_count / BF) % 2) == 1;
    c  = text_mem[(y / 16) * 160 + x / 8];
    fl = font_rom[int'(c[7:0]) * 16 + y % 16];
    on = fl[x % 8];
    if (c[15] && ph) on = 1'b0;
    if (cursor_en && int'(cursor_col) == x / 8 && int'(cursor_row) == y / 16 &&
        (y % 16) >= 14 && !ph) on = 1'b1;
    return on ? ref_pal(int'(c[11:8])) : ref_pal(int'(c[14:12]));
  endfunction

  // Outputs sampled after return reflect the inputs driven by this call.
  task automatic step(input bit d, input int x, input int y, input bit ft, input bit rst);
    disp = d; x_pos = 11'(x); y_pos = 10'(y); frame_tick = ft; reset = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int y);
    step(1'b0, 0, y, 1'b1, 1'b0);
    tick_count++;
  endtask

  task automatic run_line(input int y, input int x_end);
    int base;
    base = (y / 16) * 160;
    pix_bad = 0; fetch_bad = 0; saw_prime = 0;
    for (int i = 0; i < HB; i++) begin
      step(1'b0, 0, y, 1'b0, 1'b0);
      if (int'(mem_if.cell_addr) == base) saw_prime = 1;
    end
    prime_addr = int'(mem_if.cell_addr);
    for (int x = 0; x < x_end; x++) begin
      step(1'b1, x, y, 1'b0, 1'b0);
      line_buf[x] = rgb;
      if (rgb !== model_rgb(x, y)) pix_bad++;
      if (x % 8 == 0 && int'(mem_if.cell_addr) != ((base + x / 8 + 1) % 16384)) fetch_bad++;
    end
  endtask

  initial begin
    logic [11:0] exp_a [8];
    exp_a = '{12'h00A, 12'h00A, 12'h00A, 12'hFFF, 12'hFFF, 12'h00A, 12'h00A, 12'h00A};

    for (int i = 0; i < 16384; i++) text_mem[i] = 16'($urandom) & 16'h7FFF;
    for (int i = 0; i < 4096; i++)  font_rom[i] = 8'($urandom);
    for (int i = 0; i < 16; i++)    font_rom[i] = 8'h00;
    font_rom[16'h41 * 16] = 8'b0001_1000;
    text_mem[0]   = 16'h1F41;
    text_mem[322] = 16'h9F41;
    text_mem[485] = 16'h2C00;

    cursor_en = 1'b0; cursor_col = 8'd5; cursor_row = 6'd3;
    for (int i = 0; i < 3; i++) step(1'b1, 0, 0, 1'b0, 1'b1);
    chk_val("rst_rgb", int'(rgb), 0);
    chk_val("rst_cell_addr", int'(mem_if.cell_addr), 0);
    chk_val("rst_font_addr", int'(mem_if.font_addr), 0);

    run_line(0, 1280);
    chk_val("line0_model_bad", pix_bad, 0);
    for (int i = 0; i < 8; i++) chk_val($sformatf("cellA_px%0d", i), int'(line_buf[i]), int'(exp_a[i]));
    step(1'b0, 0, 16, 1'b0, 1'b0);
    chk_val("blank_black", int'(rgb), 0);

    run_line(16, 1280);
    chk_val("y16_prime160_seen", saw_prime, 1);
    chk_val("y16_prime_next", prime_addr, 161);
    chk_val("y16_fetch_order_bad", fetch_bad, 0);
    chk_val("y16_model_bad", pix_bad, 0);

    for (int f = 0; f < 5; f++) begin
      run_line(32, 24);
      chk_val($sformatf("blink_f%0d_px19", f), int'(line_buf[19]), (f % 4 < 2) ? 12'hFFF : 12'h00A);
      chk_val($sformatf("blink_f%0d_px16", f), int'(line_buf[16]), 12'h00A);
      chk_val($sformatf("blink_f%0d_model_bad", f), pix_bad, 0);
      if (f < 4) tick(32);
    end

    cursor_en = 1'b1;
    foreach (exp_a[k]) exp_a[k] = 12'h0;
    begin
      int ys [4];
      int ev [4];
      ys = '{48, 61, 62, 63};
      ev = '{12'h0A0, 12'h0A0, 12'hF55, 12'hF55};
      for (int k = 0; k < 4; k++) begin
        int bad;
        run_line(ys[k], 48);
        bad = 0;
        for (int x = 40; x < 48; x++) if (line_buf[x] !== 12'(ev[k])) bad++;
        chk_val($sformatf("cursor_y%0d_bad", ys[k]), bad, 0);
        chk_val($sformatf("cursor_y%0d_model_bad", ys[k]), pix_bad, 0);
      end
      tick(48);
      tick(48);
      run_line(62, 48);
      bad_loop: begin
        int bad;
        bad = 0;
        for (int x = 40; x < 48; x++) if (line_buf[x] !== 12'h0A0) bad++;
        chk_val("cursor_phase1_bad", bad, 0);
      end
    end

    cursor_en = 1'b0;
    for (int i = 0; i < HB; i++) step(1'b0, 0, 100, 1'b0, 1'b0);
    for (int x = 0; x < 300; x++) step(1'b1, x, 100, 1'b0, 1'b0);
    step(1'b1, 300, 100, 1'b0, 1'b1);
    tick_count = 0;
    chk_val("rst_mid_black", int'(rgb), 0);
    chk_val("rst_mid_cell_addr", int'(mem_if.cell_addr), 0);
    for (int x = 301; x < 1280; x++) step(1'b1, x, 100, 1'b0, 1'b0);
    run_line(101, 1280);
    chk_val("post_rst_model_bad", pix_bad, 0);
    chk_val("post_rst_fetch_bad", fetch_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
